// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
// State encoding, widths and the divide-by-zero quotient.
package divider_pkg;
  localparam int DIV_WIDTH = 16;
  localparam int CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_QUOTIENT = '1;
endpackage

// File: rtl/restoring_divider16_if.sv
// Start/done handshake and operand/result bundle of the divider.
// The master issues operands; the slave returns results.
interface restoring_divider16_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/subtractor17.sv
// Ripple subtractor a + ~b + 1 built from full-adder cells.
// borrow is the inverted final carry.
module subtractor17 #(
  parameter int W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);
  logic [W:0]   c;
  logic [W-1:0] nb;

  assign nb   = ~b;
  assign c[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign diff[i]  = a[i] ^ nb[i] ^ c[i];
    assign c[i+1]   = (a[i] & nb[i]) | (a[i] & c[i]) | (nb[i] & c[i]);
  end

  assign borrow = ~c[W];
endmodule

// File: rtl/restoring_divider16.sv
// Unsigned restoring divider, one quotient bit per clock.
// FSM, counter and shift registers; trial subtract in subtractor17.
module restoring_divider16
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic clk,
  input logic rst,
  restoring_divider16_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             take;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  assign r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  subtractor17 #(.W(WIDTH + 1)) u_sub (
    .a     (r_sh),
    .b     ({1'b0, d_q}),
    .diff  (diff),
    .borrow(borrow)
  );

  // A set R MSB means the shifted value exceeds any divisor.
  assign take   = ~borrow | r_q[WIDTH];
  assign r_next = take ? diff : r_sh;
  assign q_next = {q_q[WIDTH-2:0], take};

  // Next-state, iteration and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            quo_d   = DIV_BY_ZERO_QUOTIENT;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            q_d     = bus.dividend;
            d_d     = bus.divisor;
            r_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = r_next;
        q_d   = q_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          quo_d   = q_next;
          rem_d   = r_next[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_restoring_divider16.sv
// Directed and random checks of restoring_divider16.
// Expected results are hand-computed or derived from the invariant.
module tb_restoring_divider16;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  restoring_divider16_if #(.W(16)) bus ();

  restoring_divider16 #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        output int lat);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_div(input string tag, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] eq,
                         input logic [15:0] er, input logic edbz,
                         input int elat);
    int lat;
    run_op(a, b, lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_quo"}, bus.quotient, eq);
    chk({tag, "_rem"}, bus.remainder, er);
    chk({tag, "_dbz"}, bus.div_by_zero, edbz);
    @(posedge clk);
    #1;
    chk({tag, "_idle"}, {bus.busy, bus.done}, 0);
  endtask

  initial begin
    int          lat;
    logic        busy_ok;
    logic        saw_done;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] prod;
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_quo", bus.quotient, 0);
    chk("rst_rem", bus.remainder, 0);
    chk("rst_dbz", bus.div_by_zero, 0);

    run_div("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17);
    run_div("dmax_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 17);
    run_div("dmax_max", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 17);
    run_div("d3_10", 16'd3, 16'd10, 16'd0, 16'd3, 1'b0, 17);
    run_div("d0_5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 17);
    run_div("dz", 16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, 1);
    run_div("d9_2", 16'd9, 16'd2, 16'd4, 16'd1, 1'b0, 17);

    // Stray starts while busy.
    bus.dividend = 16'd100;
    bus.divisor  = 16'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat     = 1;
    busy_ok = 1'b1;
    while (!bus.done && lat < 40) begin
      if (lat == 5 || lat == 10) begin
        bus.start    = 1'b1;
        bus.dividend = 16'd999;
        bus.divisor  = 16'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (!bus.busy) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
    chk("ign_lat", lat, 17);
    chk("ign_quo", bus.quotient, 14);
    chk("ign_rem", bus.remainder, 2);
    chk("ign_busy", busy_ok, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("ign_idle", {bus.busy, bus.done}, 0);

    // Abort by reset mid-run.
    bus.dividend = 16'd1000;
    bus.divisor  = 16'd3;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abt_busy", bus.busy, 0);
    chk("abt_done", bus.done, 0);
    chk("abt_quo", bus.quotient, 0);
    chk("abt_rem", bus.remainder, 0);
    chk("abt_dbz", bus.div_by_zero, 0);
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("abt_quiet", saw_done, 0);
    run_div("d50000_123", 16'd50000, 16'd123, 16'd406, 16'd62, 1'b0, 17);

    // Random operands against the division invariant.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(1, 65535));
      run_op(ra, rb, lat);
      prod = 32'(bus.quotient) * 32'(rb) + 32'(bus.remainder);
      chk("rnd_ok", {lat == 17, prod == 32'(ra), bus.remainder < rb}, 3'b111);
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
